e203_exu_oitf_trk: RTL
======================

# e203_exu_oitf_trk

Outstanding-instruction tracking FIFO for the long-pipe path. The dispatch stage allocates one entry per long-pipe instruction (LSU, EAI) and receives its itag. Entries are retired in order by the long-pipe write-back arbiter, which compares each returning itag against the head pointer. The block also reports RAW/WAW hazards of the dispatching instruction against all valid entries.

## Interface
- DEPTH, 2: number of entries; power of two, ≥2.
- ITAG_W, log2(DEPTH): itag width; must equal `E203_ITAG_WIDTH`.
- RFIDX_W, 5: register index width.
- PC_W, 32: PC width.

- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dis_ena  in  1  allocate an entry this cycle; honoured only when dis_ready=1.
- dis_ready  out  1  ~full.
- dis_ptr  out  ITAG_W  itag assigned to the current allocation (alloc pointer, without wrap bit).
- dis_rdidx  in  RFIDX_W  destination register index.
- dis_rdwen  in  1  instruction writes a register.
- dis_rdfpu  in  1  destination is in the FPU register file.
- dis_pc  in  PC_W  instruction PC.
- disrs1_en, disrs2_en, disrs3_en, disrd_en  in  1 each  operand/destination valid for the hazard check.
- disrs1_idx, disrs2_idx, disrs3_idx  in  RFIDX_W each  source indices.
- disrs1_fpu, disrs2_fpu, disrs3_fpu  in  1 each  source is an FPU register.
- oitfrd_match_disrs1, oitfrd_match_disrs2, oitfrd_match_disrs3, oitfrd_match_disrd  out  1 each  hazard flags.
- ret_ena  in  1  retire the head entry.
- oitf_empty  out  1  no valid entries.
- ret_ptr  out  ITAG_W  head itag.
- ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc  out  payload of the head entry.

## Operation
- Storage:
  - DEPTH entries of {vld, rdidx, rdwen, rdfpu, pc}.
  - alloc_ptr and ret_ptr_r are ITAG_W+1 bits each; the MSB is the wrap flag.
- Status:
  - empty = (alloc_ptr == ret_ptr_r).
  - full = (low bits equal) & (wrap flags differ).
- Allocate (alloc_fire = dis_ena & ~full):
  - Write the payload into entry alloc_ptr[ITAG_W-1:0] and set its vld.
  - Increment alloc_ptr; wrap-around from DEPTH-1 to 0 toggles the wrap flag.
  - dis_ena while full is ignored: no state change.
- Retire (ret_fire = ret_ena & ~empty):
  - Clear vld of the head entry and increment ret_ptr_r.
  - ret_ena while empty is ignored.
- Simultaneous alloc_fire and ret_fire:
  - Both take effect in the same cycle, so occupancy is unchanged.
  - When full, dis_ready=0, so only the retire happens; the freed slot is visible next cycle.
  - When empty, only the allocation happens; a new entry cannot be retired in its allocation cycle.
- Head outputs (combinational):
  - ret_ptr = ret_ptr_r[ITAG_W-1:0].
  - ret_* = payload of the head entry.
  - These are don't-care when empty, but must be driven from storage with no X.
- Hazard flags (combinational):
  - oitfrd_match_disrsN = disrsN_en & OR over entries of (vld & rdwen & rdidx==disrsN_idx & rdfpu==disrsN_fpu).
  - oitfrd_match_disrd uses dis_rdidx/dis_rdfpu gated by disrd_en.
  - The check uses registered state only; an allocation or retire in the current cycle does not affect it.

## Timing
- Reset (asynchronous, immediate):
  - Pointers = 0, all vld = 0, payload = 0.
  - oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_rdidx=0, ret_rdwen=0, ret_rdfpu=0, ret_pc=0, all match flags=0.
- Reset asserted mid-operation discards all entries; after release the FIFO starts empty.
- Allocation latency:
  - The entry is visible at the head and in the hazard check from the cycle after alloc_fire.
  - oitf_empty falls on that same edge.
- Retire latency: the next head is presented the cycle after ret_fire.
- dis_ready depends only on registered state, with no combinational path from dis_ena or ret_ena.
- Throughput: one allocation and one retire per cycle sustained.

## Test plan
- Reset, then allocate rd=x5, pc=0x80000010, rdwen=1:
  - The cycle after: oitf_empty=0, ret_ptr=0, ret_rdidx=5, ret_pc=0x80000010, dis_ptr=1.
- DEPTH=2, allocate twice without retire:
  - dis_ready=0.
  - A third dis_ena is ignored: ret fields unchanged, dis_ptr=0.
  - One ret_ena, then dis_ready=1 next cycle.
- Full FIFO with ret_ena and dis_ena asserted together:
  - Only the retire occurs.
  - Next cycle: ret_ptr=1, dis_ready=1.
- Empty FIFO with ret_ena=1 and dis_ena=1 together:
  - The allocation occurs and the retire is ignored.
  - Next cycle: oitf_empty=0, ret_ptr=0.
- Hazard check:
  - Entry x7 valid with rdwen=1, rdfpu=0.
  - disrs1_idx=7, disrs1_en=1, disrs1_fpu=0 gives oitfrd_match_disrs1=1.
  - Setting disrs1_fpu=1 gives 0; setting disrs1_en=0 gives 0.
  - An entry with rdwen=0 never matches.
- Wrap-around:
  - Over 10 alloc/retire pairs, itags sequence 0,1,0,1,...
  - Each retired head's payload matches its allocation order.
  - Assert rst mid-stream: oitf_empty=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding-instruction tracking FIFO for the long pipe: in-order alloc/retire
// of itags plus RAW/WAW hazard detection of the dispatching instruction.
module e203_exu_oitf_trk #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned ITAG_W  = $clog2(DEPTH),
   parameter int unsigned RFIDX_W = 5,
   parameter int unsigned PC_W    = 32
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               dis_ena,
   output logic               dis_ready,
   output logic [ITAG_W-1:0]  dis_ptr,
   input  logic [RFIDX_W-1:0] dis_rdidx,
   input  logic               dis_rdwen,
   input  logic               dis_rdfpu,
   input  logic [PC_W-1:0]    dis_pc,

   input  logic               disrs1_en,
   input  logic               disrs2_en,
   input  logic               disrs3_en,
   input  logic               disrd_en,
   input  logic [RFIDX_W-1:0] disrs1_idx,
   input  logic [RFIDX_W-1:0] disrs2_idx,
   input  logic [RFIDX_W-1:0] disrs3_idx,
   input  logic               disrs1_fpu,
   input  logic               disrs2_fpu,
   input  logic               disrs3_fpu,
   output logic               oitfrd_match_disrs1,
   output logic               oitfrd_match_disrs2,
   output logic               oitfrd_match_disrs3,
   output logic               oitfrd_match_disrd,

   input  logic               ret_ena,
   output logic               oitf_empty,
   output logic [ITAG_W-1:0]  ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic               ret_rdwen,
   output logic               ret_rdfpu,
   output logic [PC_W-1:0]    ret_pc
);

   localparam int unsigned PTR_W = ITAG_W + 1;

   logic [PTR_W-1:0]   r_alloc_ptr;
   logic [PTR_W-1:0]   r_ret_ptr;
   logic [DEPTH-1:0]   r_vld;
   logic [RFIDX_W-1:0] r_rdidx [DEPTH];
   logic               r_rdwen [DEPTH];
   logic               r_rdfpu [DEPTH];
   logic [PC_W-1:0]    r_pc    [DEPTH];

   logic               w_empty;
   logic               w_full;
   logic               w_alloc_fire;
   logic               w_ret_fire;
   logic [ITAG_W-1:0]  w_alloc_idx;
   logic [ITAG_W-1:0]  w_ret_idx;
   logic               w_hit_rs1;
   logic               w_hit_rs2;
   logic               w_hit_rs3;
   logic               w_hit_rd;

   assign w_alloc_idx  = r_alloc_ptr[ITAG_W-1:0];
   assign w_ret_idx    = r_ret_ptr[ITAG_W-1:0];
   assign w_empty      = (r_alloc_ptr == r_ret_ptr);
   assign w_full       = (w_alloc_idx == w_ret_idx) &
                         (r_alloc_ptr[ITAG_W] != r_ret_ptr[ITAG_W]);
   assign w_alloc_fire = dis_ena & ~w_full;
   assign w_ret_fire   = ret_ena & ~w_empty;

   // Pointers carry a wrap bit; DEPTH is a power of two so +1 wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alloc_ptr <= '0;
         r_ret_ptr   <= '0;
      end else begin
         if (w_alloc_fire) r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
         if (w_ret_fire)   r_ret_ptr   <= r_ret_ptr + PTR_W'(1);
      end
   end

   // Entry storage; alloc and retire never target the same slot in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_rdidx[i] <= '0;
            r_rdwen[i] <= 1'b0;
            r_rdfpu[i] <= 1'b0;
            r_pc[i]    <= '0;
         end
      end else begin
         if (w_ret_fire) r_vld[w_ret_idx] <= 1'b0;
         if (w_alloc_fire) begin
            r_vld[w_alloc_idx]   <= 1'b1;
            r_rdidx[w_alloc_idx] <= dis_rdidx;
            r_rdwen[w_alloc_idx] <= dis_rdwen;
            r_rdfpu[w_alloc_idx] <= dis_rdfpu;
            r_pc[w_alloc_idx]    <= dis_pc;
         end
      end
   end

   // Hazard scan over registered entries only.
   always_comb begin
      w_hit_rs1 = 1'b0;
      w_hit_rs2 = 1'b0;
      w_hit_rs3 = 1'b0;
      w_hit_rd  = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (r_vld[i] && r_rdwen[i]) begin
            if (r_rdidx[i] == disrs1_idx && r_rdfpu[i] == disrs1_fpu) w_hit_rs1 = 1'b1;
            if (r_rdidx[i] == disrs2_idx && r_rdfpu[i] == disrs2_fpu) w_hit_rs2 = 1'b1;
            if (r_rdidx[i] == disrs3_idx && r_rdfpu[i] == disrs3_fpu) w_hit_rs3 = 1'b1;
            if (r_rdidx[i] == dis_rdidx  && r_rdfpu[i] == dis_rdfpu)  w_hit_rd  = 1'b1;
         end
      end
   end

   assign oitfrd_match_disrs1 = disrs1_en & w_hit_rs1;
   assign oitfrd_match_disrs2 = disrs2_en & w_hit_rs2;
   assign oitfrd_match_disrs3 = disrs3_en & w_hit_rs3;
   assign oitfrd_match_disrd  = disrd_en  & w_hit_rd;

   assign dis_ready  = ~w_full;
   assign dis_ptr    = w_alloc_idx;
   assign oitf_empty = w_empty;
   assign ret_ptr    = w_ret_idx;
   assign ret_rdidx  = r_rdidx[w_ret_idx];
   assign ret_rdwen  = r_rdwen[w_ret_idx];
   assign ret_rdfpu  = r_rdfpu[w_ret_idx];
   assign ret_pc     = r_pc[w_ret_idx];

endmodule
